// File: rtl/serdes_window.sv
// serdes_window: moves a window of 1..N words of width W between an external
// wide buffer and word-wide serializer/deserializer streams. Each command
// carries its own length; serialize, deserialize or both run concurrently,
// and a registered done pulse follows the final transfer.
//
// Build option SERDES_WINDOW_ROTATE_EN: when defined, a serialize-only
// command feeds word 0 back into the top of the window so the buffer is
// preserved; when undefined, the vacated word is filled with zero.
module serdes_window #(
  parameter int W = 64,
  parameter int N = 4,
  parameter int L = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_startDes,
  input  logic           cmd_startSer,
  input  logic [L-1:0]   cmd_len,
  output logic           cmd_canReceive,
  input  logic [W*N-1:0] buffer_read,
  output logic [W*N-1:0] buffer_write,
  input  logic [W-1:0]   des,
  input  logic           des_isReady,
  output logic           des_canReceive,
  output logic           des_isLast,
  output logic [W-1:0]   ser,
  output logic           ser_isReady,
  input  logic           ser_canReceive,
  output logic           ser_isLast,
  output logic           busy,
  output logic           done
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t       state_q, state_d;
  logic         is_ser_q, is_ser_d;
  logic         is_des_q, is_des_d;
  logic [L-1:0] len_q, len_d;
  logic [L-1:0] remaining_q, remaining_d;
  logic         done_q, done_d;

  // Clamp a requested length: zero or anything beyond N means a full window.
  function automatic logic [L-1:0] eff_len(input logic [L-1:0] len);
    if (len == '0 || len > L'(N)) eff_len = L'(N);
    else                          eff_len = len;
  endfunction

  // In the accept cycle the command fields come straight from the request
  // so the first transfer can happen with zero latency.
  logic         start;
  logic         active;
  logic         mode_ser;
  logic         mode_des;
  logic [L-1:0] eff;
  logic [L-1:0] rem;
  logic         xfer;
  logic         is_last;

  assign start    = (state_q == IDLE) && (cmd_startDes || cmd_startSer);
  assign active   = (state_q == ACTIVE) || start;
  assign mode_ser = start ? cmd_startSer     : is_ser_q;
  assign mode_des = start ? cmd_startDes     : is_des_q;
  assign eff      = start ? eff_len(cmd_len) : len_q;
  assign rem      = start ? eff_len(cmd_len) : remaining_q;

  assign xfer    = active && (mode_des ? des_isReady : 1'b1)
                          && (mode_ser ? ser_canReceive : 1'b1);
  assign is_last = xfer && (rem == L'(1));

  // Handshakes never depend on the same stream's own valid/ready input.
  assign des_canReceive = active && mode_des && (mode_ser ? ser_canReceive : 1'b1);
  assign ser_isReady    = active && mode_ser && (mode_des ? des_isReady : 1'b1);
  assign des_isLast     = is_last;
  assign ser_isLast     = is_last;
  assign ser            = buffer_read[W-1:0];
  assign cmd_canReceive = (state_q == IDLE);
  assign busy           = (state_q == ACTIVE);
  assign done           = done_q;

  // Word view of the buffer with one zero word past the end, so the
  // "next word" lookup stays in range for the top entry.
  logic [W-1:0] rd_w [N+1];
  logic [W-1:0] ser_fill;
  logic [W-1:0] fill_w;

  // Split the flat buffer into words.
  always_comb begin
    for (int k = 0; k < N; k++) rd_w[k] = buffer_read[k*W +: W];
    rd_w[N] = '0;
  end

`ifdef SERDES_WINDOW_ROTATE_EN
  assign ser_fill = rd_w[0];
`else
  assign ser_fill = '0;
`endif

  assign fill_w = mode_des ? des : ser_fill;

  // Shift the active window down one word per transfer; words past the
  // window pass through untouched.
  always_comb begin
    buffer_write = buffer_read;
    if (xfer) begin
      for (int k = 0; k < N; k++) begin
        if (k < int'(eff) - 1)       buffer_write[k*W +: W] = rd_w[k+1];
        else if (k == int'(eff) - 1) buffer_write[k*W +: W] = fill_w;
      end
    end
  end

  // Next-state: capture the command on accept, count transfers, return to
  // IDLE after the final one and raise done for the following cycle.
  always_comb begin
    state_d     = state_q;
    is_ser_d    = is_ser_q;
    is_des_d    = is_des_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    done_d      = is_last;
    if (start) begin
      is_ser_d = cmd_startSer;
      is_des_d = cmd_startDes;
      len_d    = eff;
      state_d  = ACTIVE;
    end
    if (active) remaining_d = xfer ? rem - L'(1) : rem;
    if (is_last) state_d = IDLE;
  end

  // Control registers; an asynchronous reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      is_ser_q    <= 1'b0;
      is_des_q    <= 1'b0;
      len_q       <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_ser_q    <= is_ser_d;
      is_des_q    <= is_des_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_serdes_window.sv
// Bench for serdes_window (W=64, N=4): directed cases plus randomized
// commands checked against a transaction-level model of the window.
module tb_serdes_window;
  localparam int W = 64;
  localparam int N = 4;
  localparam int L = $clog2(N + 1);
`ifdef SERDES_WINDOW_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_startDes, cmd_startSer;
  logic [L-1:0]   cmd_len;
  logic           cmd_canReceive;
  logic [W*N-1:0] buffer_read, buffer_write;
  logic [W-1:0]   des, ser;
  logic           des_isReady, des_canReceive, des_isLast;
  logic           ser_isReady, ser_canReceive, ser_isLast;
  logic           busy, done;

  always #5 clk = ~clk;

  serdes_window #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst),
    .cmd_startDes(cmd_startDes), .cmd_startSer(cmd_startSer), .cmd_len(cmd_len),
    .cmd_canReceive(cmd_canReceive),
    .buffer_read(buffer_read), .buffer_write(buffer_write),
    .des(des), .des_isReady(des_isReady), .des_canReceive(des_canReceive),
    .des_isLast(des_isLast),
    .ser(ser), .ser_isReady(ser_isReady), .ser_canReceive(ser_canReceive),
    .ser_isLast(ser_isLast),
    .busy(busy), .done(done)
  );

  // External buffer register owned by the bench.
  logic [W*N-1:0] bufr_q, load_val;
  logic           load_en;
  always @(posedge clk) bufr_q <= load_en ? load_val : buffer_write;
  assign buffer_read = bufr_q;

  int n_vec = 0;
  int n_bad = 0;
  bit exp_done = 1'b0;

  task automatic chk(input string tag, input logic [W*N-1:0] got, input logic [W*N-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [W*N-1:0] rnd_buf();
    logic [W*N-1:0] v;
    for (int k = 0; k < 2*N; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [W*N-1:0] pack4(input logic [W-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // One cycle with no start request; optionally loads the buffer.
  task automatic idle_cycle(input bit do_load, input logic [W*N-1:0] val);
    cmd_startDes   = 1'b0;
    cmd_startSer   = 1'b0;
    cmd_len        = L'($urandom);
    des_isReady    = 1'($urandom);
    ser_canReceive = 1'($urandom);
    des            = {$urandom, $urandom};
    load_en        = do_load;
    load_val       = val;
    #3;
    chk("idle_cmd_canReceive", cmd_canReceive, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, exp_done);
    chk("idle_des_canReceive", des_canReceive, 0);
    chk("idle_ser_isReady", ser_isReady, 0);
    chk("idle_isLast", {des_isLast, ser_isLast}, 0);
    chk("idle_passthru", buffer_write, buffer_read);
    exp_done = 1'b0;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Runs one command from its accept cycle to its final transfer.
  // abort_after >= 0 pulls reset after that many transfers instead.
  task automatic run_cmd(input bit s, input bit d, input int len_in, input int stall_n,
                         input bit rnd, input logic [W-1:0] dbase, input int abort_after);
    int eff, cnt, cyc;
    bit dr, sr, xf;
    logic [W-1:0] orig [N];
    logic [W-1:0] dw   [N];
    logic [W-1:0] fin  [N];
    eff = (len_in == 0 || len_in > N) ? N : len_in;
    cnt = 0;
    cyc = 0;
    for (int k = 0; k < N; k++) begin
      orig[k] = bufr_q[k*W +: W];
      dw[k]   = (dbase != '0) ? dbase + W'(k) : {$urandom, $urandom};
    end
    while (cnt < eff) begin
      if (cnt == abort_after) begin
        cmd_startDes = 1'b0; cmd_startSer = 1'b0;
        des_isReady = 1'b1; ser_canReceive = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_cmd_canReceive", cmd_canReceive, 1);
        chk("rst_busy", busy, 0);
        chk("rst_des_canReceive", des_canReceive, 0);
        chk("rst_ser_isReady", ser_isReady, 0);
        chk("rst_isLast", {des_isLast, ser_isLast}, 0);
        @(posedge clk); #1;
        chk("rst_no_done", done, 0);
        rst = 1'b1;
        exp_done = 1'b0;
        return;
      end
      if (cyc > 200) begin
        chk("xfer_timeout", cnt, eff);
        return;
      end
      if (cyc == 0) begin
        cmd_startSer = s; cmd_startDes = d; cmd_len = L'(len_in);
      end else begin
        cmd_startSer = 1'($urandom); cmd_startDes = 1'($urandom); cmd_len = L'($urandom);
      end
      dr = (cyc < stall_n) ? 1'b0 : (rnd ? 1'($urandom) : 1'b1);
      sr = (cyc < stall_n) ? 1'b0 : (rnd ? 1'($urandom) : 1'b1);
      des_isReady    = dr;
      ser_canReceive = sr;
      des            = dw[cnt];
      xf = (!d || dr) && (!s || sr);
      #3;
      chk("cmd_canReceive", cmd_canReceive, (cyc == 0));
      chk("busy", busy, (cyc != 0));
      chk("done", done, exp_done);
      chk("des_canReceive", des_canReceive, d && (!s || sr));
      chk("ser_isReady", ser_isReady, s && (!d || dr));
      chk("des_isLast", des_isLast, xf && (cnt == eff - 1));
      chk("ser_isLast", ser_isLast, xf && (cnt == eff - 1));
      if (s && xf) chk("ser_word", ser, orig[cnt]);
      exp_done = xf && (cnt == eff - 1);
      if (xf) cnt++;
      cyc++;
      @(posedge clk); #1;
    end
    for (int k = 0; k < N; k++) begin
      if (k >= eff)  fin[k] = orig[k];
      else if (d)    fin[k] = dw[k];
      else if (ROT)  fin[k] = orig[k];
      else           fin[k] = '0;
      chk($sformatf("buf_word%0d", k), bufr_q[k*W +: W], fin[k]);
    end
  endtask

  initial begin
    rst = 1'b0;
    cmd_startDes = 1'b0; cmd_startSer = 1'b0; cmd_len = '0;
    des = '0; des_isReady = 1'b0; ser_canReceive = 1'b0;
    load_en = 1'b1; load_val = rnd_buf();
    #3;
    chk("reset_cmd_canReceive", cmd_canReceive, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_des_canReceive", des_canReceive, 0);
    chk("reset_ser_isReady", ser_isReady, 0);
    chk("reset_isLast", {des_isLast, ser_isLast}, 0);
    repeat (2) @(posedge clk);
    #1;
    load_en = 1'b0;
    rst = 1'b1;

    // Deserialize A,B,C,D into a full window.
    run_cmd(1'b0, 1'b1, 4, 0, 1'b0, 64'hA, -1);
    idle_cycle(1'b1, pack4(64'd1, 64'd2, 64'd3, 64'd4));

    // Serialize two words with the sink stalled for two cycles.
    run_cmd(1'b1, 1'b0, 2, 2, 1'b0, '0, -1);
    idle_cycle(1'b1, pack4(64'd5, 64'd6, 64'd7, 64'd8));

    // Simultaneous serialize and deserialize of three words.
    run_cmd(1'b1, 1'b1, 3, 0, 1'b0, 64'h10, -1);
    idle_cycle(1'b0, '0);

    // Length 0 and 7 both mean a full window; length 1 finishes at once.
    // Back-to-back, so each accept lands in the previous done cycle.
    run_cmd(1'b0, 1'b1, 0, 0, 1'b0, '0, -1);
    run_cmd(1'b1, 1'b0, 7, 0, 1'b0, '0, -1);
    run_cmd(1'b1, 1'b1, 1, 0, 1'b0, '0, -1);
    run_cmd(1'b0, 1'b1, 1, 0, 1'b0, '0, -1);
    idle_cycle(1'b0, '0);

    // Reset after two of four transfers, then a fresh full command.
    run_cmd(1'b0, 1'b1, 4, 0, 1'b0, '0, 2);
    run_cmd(1'b0, 1'b1, 4, 0, 1'b0, '0, -1);
    idle_cycle(1'b0, '0);

    // Randomized commands with random stalls and gaps.
    for (int i = 0; i < 40; i++) begin
      int m;
      m = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) idle_cycle(1'b1, rnd_buf());
      run_cmd(m[0], m[1], int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              1'b1, '0, -1);
    end
    idle_cycle(1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
